// File: rtl/id_stage_hazard_pipe.sv
// id_stage_hazard_pipe: MIPS decode stage and ID/EX register (regfile with WB bypass, imm/jump/rd select, load-use bubble)
// Optional saturating perf counters (lu_stall_cnt, flush_cnt) are built when ID_STAGE_PERF_CNT_EN is defined.
module id_stage_hazard_pipe #(
    parameter int XLEN      = 32,
    parameter int CTRL_W    = 8,
    parameter int WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pcplus4_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              regwrite_d,
    input  logic              memread_d,
    input  logic              regdest_d,
    input  logic              link_d,
    input  logic              zext_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_d,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              regwrite_e,
    output logic              memread_e,
    output logic [XLEN-1:0]   op1_e,
    output logic [XLEN-1:0]   op2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   jtarget_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcplus4_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e
`ifdef ID_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]       lu_stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    logic [XLEN-1:0] regFile [32];
    logic [4:0]      rs1, rs2, rdSel;
    logic [XLEN-1:0] rdata1, rdata2, immExt, jTarget;
    logic            luHazard;
    logic            unusedOpcode;

    // decode: register reads with optional same-cycle write-back forwarding, imm, jump target, rd, hazard, stall
    always_comb begin
        rs1          = instr_d[25:21];
        rs2          = instr_d[20:16];
        unusedOpcode = ^instr_d[31:26];
        rdata1       = (rs1 == 5'd0) ? '0 :
                       ((WB_BYPASS != 0) && wb_we && wb_rd == rs1) ? wb_data : regFile[rs1];
        rdata2       = (rs2 == 5'd0) ? '0 :
                       ((WB_BYPASS != 0) && wb_we && wb_rd == rs2) ? wb_data : regFile[rs2];
        immExt       = zext_d ? {{(XLEN-16){1'b0}}, instr_d[15:0]} : {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};
        jTarget      = {pcplus4_d[XLEN-1:28], instr_d[25:0], 2'b00};
        rdSel        = link_d ? 5'd31 : regdest_d ? instr_d[15:11] : instr_d[20:16];
        luHazard     = valid_d && valid_e && memread_e && rd_e != 5'd0 &&
                       ((use_rs1_d && rd_e == rs1) || (use_rs2_d && rd_e == rs2));
        stall_d      = !rst && !flush && (!ex_ready || luHazard);
    end

    // register file: r0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < 32; i++) regFile[i] <= '0;
        else if (wb_we && wb_rd != 5'd0)
            regFile[wb_rd] <= wb_data;
    end

    // ID/EX register: flush > hold on !ex_ready > load-use bubble > empty bubble > capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (ex_ready && (luHazard || !valid_d))) begin
            valid_e    <= 1'b0;
            ctrl_e     <= '0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
            op1_e      <= '0;
            op2_e      <= '0;
            imm_e      <= '0;
            jtarget_e  <= '0;
            pc_e       <= '0;
            pcplus4_e  <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
        end else if (ex_ready) begin
            valid_e    <= 1'b1;
            ctrl_e     <= ctrl_d;
            regwrite_e <= regwrite_d;
            memread_e  <= memread_d;
            op1_e      <= rdata1;
            op2_e      <= rdata2;
            imm_e      <= immExt;
            jtarget_e  <= jTarget;
            pc_e       <= pc_d;
            pcplus4_e  <= pcplus4_d;
            rs1_e      <= rs1;
            rs2_e      <= rs2;
            rd_e       <= rdSel;
        end
    end

`ifdef ID_STAGE_PERF_CNT_EN
    // saturating counters of load-use bubbles and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (!flush && ex_ready && luHazard && lu_stall_cnt != 32'hFFFF_FFFF)
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            if (flush && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_stage_hazard_pipe.sv
// tb_id_stage_hazard_pipe: scoreboard bench for id_stage_hazard_pipe (bypass and non-bypass instances)
module tb_id_stage_hazard_pipe;
    logic        clk = 1'b0, rst = 1'b0;
    logic        valid_d, regwrite_d, memread_d, regdest_d, link_d, zext_d, use_rs1_d, use_rs2_d;
    logic        flush, ex_ready, wb_we;
    logic [31:0] instr_d, pc_d, pcplus4_d, wb_data;
    logic [7:0]  ctrl_d;
    logic [4:0]  wb_rd;
    logic        stall_d, valid_e, regwrite_e, memread_e;
    logic [7:0]  ctrl_e;
    logic [31:0] op1_e, op2_e, imm_e, jtarget_e, pc_e, pcplus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        stall0, valid0, rw0, mr0;
    logic [7:0]  ctrl0;
    logic [31:0] op1_0, op2_0, imm0, jt0, pc0, pcp4_0;
    logic [4:0]  rs1_0, rs2_0, rd0;
`ifdef ID_STAGE_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, flush_cnt, luCnt0, flushCnt0;
`endif
    int errors = 0, checks = 0;

    typedef struct {
        logic        v;
        logic        rw;
        logic        mr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
    } exp_t;
    exp_t        expQ[$];
    logic [31:0] regModel [8];

    id_stage_hazard_pipe #(.XLEN(32), .CTRL_W(8), .WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
        .ctrl_d(ctrl_d), .regwrite_d(regwrite_d), .memread_d(memread_d), .regdest_d(regdest_d),
        .link_d(link_d), .zext_d(zext_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .flush(flush),
        .ex_ready(ex_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_d(stall_d),
        .valid_e(valid_e), .ctrl_e(ctrl_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .op1_e(op1_e), .op2_e(op2_e), .imm_e(imm_e), .jtarget_e(jtarget_e), .pc_e(pc_e),
        .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
`ifdef ID_STAGE_PERF_CNT_EN
        , .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    id_stage_hazard_pipe #(.XLEN(32), .CTRL_W(8), .WB_BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
        .ctrl_d(ctrl_d), .regwrite_d(regwrite_d), .memread_d(memread_d), .regdest_d(regdest_d),
        .link_d(link_d), .zext_d(zext_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .flush(flush),
        .ex_ready(ex_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_d(stall0),
        .valid_e(valid0), .ctrl_e(ctrl0), .regwrite_e(rw0), .memread_e(mr0),
        .op1_e(op1_0), .op2_e(op2_0), .imm_e(imm0), .jtarget_e(jt0), .pc_e(pc0),
        .pcplus4_e(pcp4_0), .rs1_e(rs1_0), .rs2_e(rs2_0), .rd_e(rd0)
`ifdef ID_STAGE_PERF_CNT_EN
        , .lu_stall_cnt(luCnt0), .flush_cnt(flushCnt0)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_d = 0; instr_d = 0; pc_d = 0; pcplus4_d = 0; ctrl_d = 0;
        regwrite_d = 0; memread_d = 0; regdest_d = 0; link_d = 0; zext_d = 0;
        use_rs1_d = 0; use_rs2_d = 0; flush = 0; ex_ready = 1; wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        #1 rst = 1;
        tick();
        checks++;
        if (valid_e !== 1'b0 || stall_d !== 1'b0 || op1_e !== 32'd0 || rd_e !== 5'd0 || ctrl_e !== 8'd0 || pc_e !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid_e=%b stall_d=%b op1_e=%h rd_e=%0d ctrl_e=%h pc_e=%h, want all 0",
                     valid_e, stall_d, op1_e, rd_e, ctrl_e, pc_e);
        end
        rst = 0;
        wb_we = 1; wb_rd = 5; wb_data = 32'h0000_0055;
        tick();
        wb_we = 0;
        valid_d = 1; instr_d = rtype(5, 0, 3); regdest_d = 1; regwrite_d = 1; use_rs1_d = 1; ctrl_d = 8'h3C;
        expQ.push_back('{v: 1'b1, rw: 1'b1, mr: 1'b0, op1: 32'h55, op2: 32'h0, rd: 5'd3});
        tick();
        e = expQ.pop_front();
        checks++;
        if (valid_e !== e.v || op1_e !== e.op1 || rd_e !== e.rd || ctrl_e !== 8'h3C) begin
            errors++;
            $display("FAIL reset_preload: valid_e=%b op1_e=%h rd_e=%0d ctrl_e=%h, want 1 %h %0d 3c",
                     valid_e, op1_e, rd_e, ctrl_e, e.op1, e.rd);
        end
        ex_ready = 0;
        #1;
        checks++;
        if (stall_d !== 1'b1) begin
            errors++;
            $display("FAIL reset_prestall: stall_d=%b want 1", stall_d);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (valid_e !== 1'b0 || op1_e !== 32'd0 || rd_e !== 5'd0 || ctrl_e !== 8'd0 || regwrite_e !== 1'b0 || stall_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid_e=%b op1_e=%h rd_e=%0d ctrl_e=%h regwrite_e=%b stall_d=%b, want all 0",
                     valid_e, op1_e, rd_e, ctrl_e, regwrite_e, stall_d);
        end
        #1 rst = 0;
        ex_ready = 1;
        expQ.push_back('{v: 1'b1, rw: 1'b1, mr: 1'b0, op1: 32'h0, op2: 32'h0, rd: 5'd3});
        tick();
        e = expQ.pop_front();
        checks++;
        if (valid_e !== e.v || op1_e !== e.op1) begin
            errors++;
            $display("FAIL reset_r5_cleared: valid_e=%b op1_e=%h, want 1 %h", valid_e, op1_e, e.op1);
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        idle();
        wb_we = 1; wb_rd = 8; wb_data = 32'h1111_1111;
        tick();
        wb_data = 32'hDEAD_BEEF;
        valid_d = 1; instr_d = rtype(8, 0, 4); regdest_d = 1; regwrite_d = 1; use_rs1_d = 1;
        expQ.push_back('{v: 1'b1, rw: 1'b1, mr: 1'b0, op1: 32'hDEAD_BEEF, op2: 32'h0, rd: 5'd4});
        tick();
        e = expQ.pop_front();
        checks++;
        if (op1_e !== e.op1 || valid_e !== e.v || rd_e !== e.rd) begin
            errors++;
            $display("FAIL bypass_same_cycle: op1_e=%h valid_e=%b rd_e=%0d, want %h 1 %0d", op1_e, valid_e, rd_e, e.op1, e.rd);
        end
        checks++;
        if (op1_0 !== 32'h1111_1111) begin
            errors++;
            $display("FAIL nobypass_old_value: op1_e=%h want 11111111", op1_0);
        end
        wb_we = 0;
        tick();
        checks++;
        if (op1_0 !== 32'hDEAD_BEEF || op1_e !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_next_cycle: op1_e=%h nobypass op1_e=%h, want deadbeef", op1_e, op1_0);
        end
        wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF; instr_d = rtype(0, 0, 4); use_rs2_d = 1;
        tick();
        checks++;
        if (op1_e !== 32'd0 || op2_e !== 32'd0) begin
            errors++;
            $display("FAIL r0_bypass: op1_e=%h op2_e=%h, want 0", op1_e, op2_e);
        end
        wb_we = 0;
        tick();
        checks++;
        if (op1_e !== 32'd0 || op1_0 !== 32'd0) begin
            errors++;
            $display("FAIL r0_write_ignored: op1_e=%h nobypass=%h, want 0", op1_e, op1_0);
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            idle();
            valid_d = 1; instr_d = {6'h23, 5'd1, 5'd9, 16'd4}; memread_d = 1; regwrite_d = 1; use_rs1_d = 1;
            tick();
            checks++;
            if (valid_e !== 1'b1 || memread_e !== 1'b1 || rd_e !== 5'd9) begin
                errors++;
                $display("FAIL lu_load_in_e[%0d]: valid_e=%b memread_e=%b rd_e=%0d, want 1 1 9", k, valid_e, memread_e, rd_e);
            end
            memread_d = 0; regdest_d = 1; use_rs1_d = 1; use_rs2_d = 1;
            instr_d = (k == 0) ? rtype(2, 9, 10) : rtype(9, 3, 11);
            #1;
            checks++;
            if (stall_d !== 1'b1) begin
                errors++;
                $display("FAIL lu_stall[%0d]: stall_d=%b want 1", k, stall_d);
            end
            expQ.push_back('{v: 1'b0, rw: 1'b0, mr: 1'b0, op1: 32'h0, op2: 32'h0, rd: 5'd0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (valid_e !== e.v || regwrite_e !== e.rw || memread_e !== e.mr || rd_e !== e.rd || stall_d !== 1'b0) begin
                errors++;
                $display("FAIL lu_bubble[%0d]: valid_e=%b regwrite_e=%b memread_e=%b rd_e=%0d stall_d=%b, want 0 0 0 0 0",
                         k, valid_e, regwrite_e, memread_e, rd_e, stall_d);
            end
            expQ.push_back('{v: 1'b1, rw: 1'b1, mr: 1'b0, op1: 32'h0, op2: 32'h0, rd: (k == 0) ? 5'd10 : 5'd11});
            tick();
            e = expQ.pop_front();
            checks++;
            if (valid_e !== e.v || regwrite_e !== e.rw || memread_e !== e.mr || rd_e !== e.rd) begin
                errors++;
                $display("FAIL lu_release[%0d]: valid_e=%b regwrite_e=%b memread_e=%b rd_e=%0d, want 1 1 0 %0d",
                         k, valid_e, regwrite_e, memread_e, rd_e, e.rd);
            end
        end
        idle();
        valid_d = 1; instr_d = {6'h23, 5'd1, 5'd9, 16'd4}; memread_d = 1; regwrite_d = 1; use_rs1_d = 1;
        tick();
        memread_d = 0; regdest_d = 1; use_rs1_d = 1; use_rs2_d = 0; instr_d = rtype(2, 9, 12);
        #1;
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL lu_unused_rt: stall_d=%b want 0", stall_d);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || rd_e !== 5'd12) begin
            errors++;
            $display("FAIL lu_unused_rt_enter: valid_e=%b rd_e=%0d, want 1 12", valid_e, rd_e);
        end
    endtask

    task automatic test_flush_ready();
        idle();
        valid_d = 1; instr_d = rtype(1, 2, 13); regdest_d = 1; regwrite_d = 1; ctrl_d = 8'hA5;
        tick();
        flush = 1; ex_ready = 0;
        #1;
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall_d=%b want 0", stall_d);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== 8'd0 || regwrite_e !== 1'b0 || rd_e !== 5'd0) begin
            errors++;
            $display("FAIL flush_over_ready: valid_e=%b ctrl_e=%h regwrite_e=%b rd_e=%0d, want 0 00 0 0",
                     valid_e, ctrl_e, regwrite_e, rd_e);
        end
        flush = 0; ex_ready = 1;
        tick();
        ex_ready = 0; instr_d = rtype(3, 4, 14); ctrl_d = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_d !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall[%0d]: stall_d=%b want 1", i, stall_d);
            end
            tick();
            checks++;
            if (valid_e !== 1'b1 || ctrl_e !== 8'hA5 || rd_e !== 5'd13 || regwrite_e !== 1'b1 || rs1_e !== 5'd1) begin
                errors++;
                $display("FAIL hold_e[%0d]: valid_e=%b ctrl_e=%h rd_e=%0d regwrite_e=%b rs1_e=%0d, want 1 a5 13 1 1",
                         i, valid_e, ctrl_e, rd_e, regwrite_e, rs1_e);
            end
        end
        ex_ready = 1; flush = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (valid_e !== 1'b0 || ctrl_e !== 8'd0) begin
                errors++;
                $display("FAIL flush_bubble[%0d]: valid_e=%b ctrl_e=%h, want 0 00", i, valid_e, ctrl_e);
            end
        end
        flush = 0;
    endtask

    task automatic test_imm_jump();
        idle();
        valid_d = 1; instr_d = 32'h3C08_8001; zext_d = 0;
        tick();
        checks++;
        if (imm_e !== 32'hFFFF_8001 || rd_e !== 5'd8) begin
            errors++;
            $display("FAIL imm_sext: imm_e=%h rd_e=%0d, want ffff8001 8", imm_e, rd_e);
        end
        zext_d = 1;
        tick();
        checks++;
        if (imm_e !== 32'h0000_8001) begin
            errors++;
            $display("FAIL imm_zext: imm_e=%h want 00008001", imm_e);
        end
        zext_d = 0; instr_d = 32'h0C00_0040; pc_d = 32'h4000_0000; pcplus4_d = 32'h4000_0004;
        link_d = 1; regdest_d = 1; regwrite_d = 1;
        tick();
        checks++;
        if (jtarget_e !== 32'h4000_0100 || rd_e !== 5'd31 || pc_e !== 32'h4000_0000 || pcplus4_e !== 32'h4000_0004) begin
            errors++;
            $display("FAIL jal: jtarget_e=%h rd_e=%0d pc_e=%h pcplus4_e=%h, want 40000100 31 40000000 40000004",
                     jtarget_e, rd_e, pc_e, pcplus4_e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [4:0] rs, rt, rd;
        idle();
        regModel[0] = 32'd0;
        for (int r = 1; r < 8; r++) begin
            wb_we = 1; wb_rd = 5'(r); wb_data = $urandom; regModel[r] = wb_data;
            tick();
        end
        wb_we = 0;
        for (int i = 0; i < 8; i++) begin
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(1, 31));
            valid_d = 1; instr_d = rtype(rs, rt, rd); regdest_d = 1; regwrite_d = 1; use_rs1_d = 1; use_rs2_d = 1;
            expQ.push_back('{v: 1'b1, rw: 1'b1, mr: 1'b0, op1: regModel[rs[2:0]], op2: regModel[rt[2:0]], rd: rd});
            tick();
            e = expQ.pop_front();
            checks++;
            if (valid_e !== e.v || regwrite_e !== e.rw || memread_e !== e.mr || op1_e !== e.op1 || op2_e !== e.op2 || rd_e !== e.rd) begin
                errors++;
                $display("FAIL b2b[%0d]: valid_e=%b rw=%b mr=%b op1_e=%h op2_e=%h rd_e=%0d, want %b %b %b %h %h %0d",
                         i, valid_e, regwrite_e, memread_e, op1_e, op2_e, rd_e, e.v, e.rw, e.mr, e.op1, e.op2, e.rd);
            end
        end
    endtask

`ifdef ID_STAGE_PERF_CNT_EN
    task automatic test_perf_cnt();
        idle();
        tick();
        checks++;
        if (lu_stall_cnt !== 32'd2 || flush_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts: lu_stall_cnt=%0d flush_cnt=%0d, want 2 3", lu_stall_cnt, flush_cnt);
        end
        force dut.lu_stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.lu_stall_cnt;
        valid_d = 1; instr_d = {6'h23, 5'd1, 5'd9, 16'd4}; memread_d = 1; regwrite_d = 1;
        tick();
        memread_d = 0; regdest_d = 1; use_rs2_d = 1; instr_d = rtype(2, 9, 10);
        tick();
        tick();
        checks++;
        if (lu_stall_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_saturate: lu_stall_cnt=%h want ffffffff", lu_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_flush_ready();
        test_imm_jump();
        test_back_to_back();
`ifdef ID_STAGE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage_hazard_pipe.md
Name: id_stage_hazard_pipe

Overview:
- Parametrised decode stage plus ID/EX pipeline register for the 5-stage MIPS core.
- Contains the register file (with write-back bypass), immediate/jump-target generation and destination select.
- Contains load-use hazard detection with bubble insertion, and a stall/flush/valid protocol between IF/ID and EX.
- Opcode decoding stays in the external control unit; this block receives its control bundle.

Parameters:
- XLEN, 32, datapath width; must be >= 32.
- CTRL_W, 8, width of the opaque control bundle passed from D to E.
- WB_BYPASS, 1, 1 = same-cycle write-back forwarded to the read ports; 0 = read returns old register value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_d  in  1  IF/ID holds a real instruction
- instr_d  in  32  instruction word
- pc_d  in  XLEN  PC of instr_d
- pcplus4_d  in  XLEN  pc_d+4
- ctrl_d  in  CTRL_W  control bundle from control unit
- regwrite_d, memread_d  in  1  write-enable / load indicators from control unit
- regdest_d, link_d, zext_d  in  1  rd=instr[15:11]; rd=31 (jal); zero-extend immediate
- use_rs1_d, use_rs2_d  in  1  instruction actually reads rs / rt
- flush  in  1  squash from branch resolution in E
- ex_ready  in  1  EX can accept a new entry this cycle
- wb_we  in  1  write-back enable
- wb_rd  in  5  write-back register
- wb_data  in  XLEN  write-back data
- stall_d  out  1  hold PC and IF/ID this cycle
- valid_e  out  1  E entry is real
- ctrl_e  out  CTRL_W  registered control bundle
- regwrite_e, memread_e  out  1  registered
- op1_e, op2_e, imm_e, jtarget_e, pc_e, pcplus4_e  out  XLEN  registered data
- rs1_e, rs2_e, rd_e  out  5  registered register addresses

Behaviour:
- Reset: every E output is 0, stall_d is 0, all 32 registers are 0. Reset is asynchronous and wins in any state, including mid-stall.
- Register file:
  - 32 x XLEN; r0 reads 0 and ignores writes.
  - Reads are combinational at instr_d[25:21] and instr_d[20:16].
  - Write happens at posedge when wb_we && wb_rd != 0.
  - With WB_BYPASS=1, a read of a register equal to wb_rd (nonzero, wb_we=1) returns wb_data in the same cycle.
- imm: instr[15:0] sign-extended to XLEN, or zero-extended when zext_d=1.
- jtarget: {pcplus4_d[XLEN-1:28], instr[25:0], 2'b00}.
- rd select: link_d ? 31 : regdest_d ? instr[15:11] : instr[20:16]; link_d wins over regdest_d.
- Load-use hazard (lu), combinational, requires all of:
  - valid_d && valid_e && memread_e && rd_e != 0;
  - and either (use_rs1_d && rd_e == rs1) or (use_rs2_d && rd_e == rs2).
- ID/EX update each posedge, first match wins:
  1. flush=1: bubble. valid_e, ctrl_e, regwrite_e and memread_e go to 0; data fields are don't-care but driven to 0; stall_d=0. Flush overrides ex_ready=0.
  2. ex_ready=0: all E registers hold; stall_d=1.
  3. lu: bubble into E; stall_d=1. The held instruction re-evaluates next cycle; lu clears since E now holds a bubble, so exactly one bubble per load-use.
  4. valid_d=0: bubble; stall_d=0.
  5. Otherwise capture all D values; valid_e=1; stall_d=0.
- A bubble must never write registers or memory downstream: regwrite_e=0 and memread_e=0 whenever valid_e=0.
- Latency: 1 cycle D→E. Register-file write is visible to a D read in the same cycle (bypass) or the next cycle.
- stall_d is combinational from the current inputs and E state.

Optional Feature:
- Macro: ID_STAGE_PERF_CNT_EN.
- Defined:
  - Adds outputs lu_stall_cnt[31:0] and flush_cnt[31:0].
  - Counters reset to 0 and saturate at 0xFFFFFFFF.
  - lu_stall_cnt increments on each cycle rule 3 is taken.
  - flush_cnt increments on each cycle rule 1 is taken.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- Reset mid-operation: drive rst async between clock edges during a stall → all E outputs 0, stall_d 0 immediately; a read of r5 after reset → 0.
- Bypass: wb_we=1, wb_rd=8, wb_data=0xDEADBEEF, instr reads rs=8 in the same cycle → op1_e=0xDEADBEEF next edge.
  - With WB_BYPASS=0: op1_e holds the old value.
  - Write to r0 → reads stay 0.
- Load-use: lw r9 in E (memread_e=1, rd_e=9), then add using rt=9 with use_rs2_d=1:
  - stall_d=1 for exactly one cycle and a bubble (valid_e=0, regwrite_e=0) in E;
  - the add enters E on the following edge.
  - Same case with use_rs2_d=0 → no stall.
- Flush vs ex_ready: flush=1 with ex_ready=0 → valid_e=0, stall_d=0. Then ex_ready=0 alone for 3 cycles → E outputs unchanged, stall_d=1 throughout.
- Immediate/jump/rd: instr 0x3C08_8001 with zext_d=0 → imm_e=0xFFFF8001; with zext_d=1 → 0x00008001.
  - jal target 0x0000040 at pcplus4=0x40000004 → jtarget_e=0x40000100, rd_e=31.
- Perf counters (macro defined): 2 load-use stalls + 3 flushes → lu_stall_cnt=2, flush_cnt=3. Force lu_stall_cnt to 0xFFFFFFFF, then one more stall → value stays 0xFFFFFFFF.
